// File: rtl/wrr_burst_arbiter.sv
// Weighted round-robin arbiter with burst/packet lock for a shared valid/ready stream.
// Optional stall watchdog is compiled in with `define ARB_WATCHDOG_EN.
module wrr_burst_arbiter #(
  parameter int REQ_WIDTH = 4,
  parameter int DW        = 8,
  parameter int CNT_W     = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [REQ_WIDTH-1:0]       valid_in,
  input  logic [REQ_WIDTH-1:0]       last_in,
  input  logic [REQ_WIDTH*DW-1:0]    data_in,
  input  logic [REQ_WIDTH*CNT_W-1:0] weight_in,
  input  logic                       ready_in,
  output logic [REQ_WIDTH-1:0]       ready_out,
  output logic                       valid_out,
  output logic                       last_out,
  output logic [DW-1:0]              data_out,
  output logic [REQ_WIDTH-1:0]       grant_out,
  output logic                       busy
);
  localparam int PW = (REQ_WIDTH > 1) ? $clog2(REQ_WIDTH) : 1;
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  logic [0:0]           r_state;
  logic [PW-1:0]        r_ptr, r_gidx;
  logic [REQ_WIDTH-1:0] r_grant;
  logic [CNT_W-1:0]     r_cnt;

  logic                 w_pick_vld;
  logic [PW-1:0]        w_pick_idx;
  logic [CNT_W-1:0]     w_pick_raw, w_pick_wt;
  logic                 w_busy, w_beat, w_release, w_timeout;
  logic [PW-1:0]        w_next_ptr;

  // Descending scan so the lowest offset from r_ptr is written last and wins.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick_idx = '0;
    for (int k = REQ_WIDTH - 1; k >= 0; k--) begin
      if (valid_in[(int'(r_ptr) + k) % REQ_WIDTH]) begin
        w_pick_vld = 1'b1;
        w_pick_idx = PW'((int'(r_ptr) + k) % REQ_WIDTH);
      end
    end
  end

  assign w_pick_raw = weight_in[w_pick_idx*CNT_W +: CNT_W];
  assign w_pick_wt  = (w_pick_raw == '0) ? CNT_W'(1) : w_pick_raw;

  assign w_busy     = (r_state == S_BURST);
  assign busy       = w_busy;
  assign grant_out  = r_grant;
  assign valid_out  = w_busy & valid_in[r_gidx];
  assign last_out   = w_busy & last_in[r_gidx];
  assign data_out   = w_busy ? data_in[r_gidx*DW +: DW] : '0;
  assign ready_out  = w_busy ? (r_grant & {REQ_WIDTH{ready_in}}) : '0;
  assign w_beat     = valid_out & ready_in;
  assign w_next_ptr = (r_gidx == PW'(REQ_WIDTH - 1)) ? '0 : r_gidx + 1'b1;

`ifdef ARB_WATCHDOG_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0] r_stall;

  // Fires on the TIMEOUT-th consecutive cycle the granted requester is idle.
  assign w_timeout = w_busy & ~valid_in[r_gidx] & (r_stall == SW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                         r_stall <= '0;
    else if (!w_busy || valid_in[r_gidx] || w_timeout) r_stall <= '0;
    else                                              r_stall <= r_stall + 1'b1;
  end
`else
  assign w_timeout = 1'b0;
`endif

  assign w_release = (w_beat & (last_in[r_gidx] | (r_cnt == CNT_W'(1)))) | w_timeout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_gidx  <= '0;
      r_grant <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pick_vld) begin
            r_state <= S_BURST;
            r_gidx  <= w_pick_idx;
            r_grant <= REQ_WIDTH'(1) << w_pick_idx;
            r_cnt   <= w_pick_wt;
          end
        end
        default: begin
          if (w_release) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_cnt   <= '0;
            r_ptr   <= w_next_ptr;
          end else if (w_beat) begin
            r_cnt   <= r_cnt - 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wrr_burst_arbiter.sv
// Directed bench for wrr_burst_arbiter: reset, fairness, weights, last, backpressure, watchdog.
module tb_wrr_burst_arbiter;
  localparam int RW = 4, DW = 8, CW = 4, TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] valid_in, last_in, ready_out, grant_out;
  logic [RW*DW-1:0] data_in;
  logic [RW*CW-1:0] weight_in;
  logic          ready_in, valid_out, last_out, busy;
  logic [DW-1:0] data_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wrr_burst_arbiter #(.REQ_WIDTH(RW), .DW(DW), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .last_in(last_in), .data_in(data_in),
    .weight_in(weight_in), .ready_in(ready_in), .ready_out(ready_out), .valid_out(valid_out),
    .last_out(last_out), .data_out(data_out), .grant_out(grant_out), .busy(busy)
  );

  function automatic logic [DW-1:0] dexp(input int i);
    return 8'hA0 + 8'(8'h11 * i);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; valid_in = '0; last_in = '0; ready_in = 1'b0;
    weight_in = {4'd1, 4'd1, 4'd1, 4'd1};
    data_in = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (grant_out !== 4'b0 || busy !== 1'b0 || valid_out !== 1'b0 || data_out !== 8'h0 || ready_out !== 4'b0) begin
      errors++; $display("FAIL reset_state: grant=%b busy=%b vld=%b data=%h rdy=%b, want all 0", grant_out, busy, valid_out, data_out, ready_out);
    end
    weight_in = {4'd8, 4'd8, 4'd8, 4'd8}; valid_in = 4'b0001; ready_in = 1'b1;
    tick(); tick();
    checks++;
    if (grant_out !== 4'b0001 || valid_out !== 1'b1) begin
      errors++; $display("FAIL reset_pre_burst: grant=%b vld=%b, want 0001/1", grant_out, valid_out);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (grant_out !== 4'b0 || busy !== 1'b0 || valid_out !== 1'b0 || data_out !== 8'h0 || ready_out !== 4'b0 || last_out !== 1'b0) begin
      errors++; $display("FAIL reset_async: grant=%b busy=%b vld=%b data=%h rdy=%b, want all 0", grant_out, busy, valid_out, data_out, ready_out);
    end
    @(posedge clk); #1 rst = 1'b1; valid_in = 4'b0100;
    tick();
    checks++;
    if (grant_out !== 4'b0100 || data_out !== dexp(2)) begin
      errors++; $display("FAIL reset_regrant: grant=%b data=%h, want 0100/%h", grant_out, data_out, dexp(2));
    end
  endtask

  task automatic test_fairness();
    logic [RW-1:0] exp_g;
    do_reset();
    valid_in = 4'hF; ready_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_g = 4'b0001 << (i % 4);
      tick();
      checks++;
      if (grant_out !== exp_g || valid_out !== 1'b1 || data_out !== dexp(i % 4) || ready_out !== exp_g) begin
        errors++; $display("FAIL fair_grant%0d: grant=%b data=%h rdy=%b, want %b/%h", i, grant_out, data_out, ready_out, exp_g, dexp(i % 4));
      end
      tick();
      checks++;
      if (grant_out !== 4'b0 || busy !== 1'b0 || valid_out !== 1'b0) begin
        errors++; $display("FAIL fair_idle%0d: grant=%b busy=%b, want 0000/0", i, grant_out, busy);
      end
    end
  endtask

  task automatic test_weight();
    logic [RW-1:0] seq [7];
    seq = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0100, 4'b0100, 4'b0000};
    do_reset();
    weight_in = {4'd1, 4'd2, 4'd3, 4'd1}; valid_in = 4'b0110; ready_in = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if (grant_out !== seq[i] || ready_out !== seq[i]) begin
        errors++; $display("FAIL weight_step%0d: grant=%b rdy=%b, want %b", i, grant_out, ready_out, seq[i]);
      end
    end
    valid_in = '0;
  endtask

  task automatic test_last();
    do_reset();
    weight_in = {4'd1, 4'd1, 4'd1, 4'd8}; valid_in = 4'b0001; ready_in = 1'b1;
    tick();
    checks++;
    if (grant_out !== 4'b0001 || last_out !== 1'b0) begin
      errors++; $display("FAIL last_beat1: grant=%b last=%b, want 0001/0", grant_out, last_out);
    end
    tick();
    last_in = 4'b0001; #1;
    checks++;
    if (grant_out !== 4'b0001 || last_out !== 1'b1 || valid_out !== 1'b1) begin
      errors++; $display("FAIL last_beat2: grant=%b last=%b vld=%b, want 0001/1/1", grant_out, last_out, valid_out);
    end
    tick();
    checks++;
    if (grant_out !== 4'b0 || last_out !== 1'b0) begin
      errors++; $display("FAIL last_release: grant=%b last=%b, want 0000/0", grant_out, last_out);
    end
    last_in = '0; valid_in = 4'hF;
    tick();
    checks++;
    if (grant_out !== 4'b0010) begin
      errors++; $display("FAIL last_ptr: grant=%b, want 0010", grant_out);
    end
    valid_in = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    weight_in = {4'd1, 4'd1, 4'd1, 4'd4}; valid_in = 4'b0001; ready_in = 1'b1;
    tick(); tick();
    ready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (grant_out !== 4'b0001 || data_out !== 8'hA0 || valid_out !== 1'b1 || ready_out !== 4'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL bp_stall%0d: grant=%b data=%h vld=%b rdy=%b", i, grant_out, data_out, valid_out, ready_out);
      end
    end
    ready_in = 1'b1;
    tick(); tick();
    checks++;
    if (grant_out !== 4'b0001) begin
      errors++; $display("FAIL bp_count_hold: grant=%b, want 0001", grant_out);
    end
    tick();
    checks++;
    if (grant_out !== 4'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_count_release: grant=%b, want 0000", grant_out);
    end
    valid_in = '0;
  endtask

  task automatic test_watchdog();
    do_reset();
    weight_in = {4'd8, 4'd8, 4'd8, 4'd8}; valid_in = 4'b0001; ready_in = 1'b1;
    tick();
    valid_in = 4'b0010;
`ifdef ARB_WATCHDOG_EN
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (grant_out !== 4'b0001) begin
        errors++; $display("FAIL wd_hold%0d: grant=%b, want 0001", i, grant_out);
      end
    end
    tick();
    checks++;
    if (grant_out !== 4'b0) begin
      errors++; $display("FAIL wd_release: grant=%b, want 0000", grant_out);
    end
    tick();
    checks++;
    if (grant_out !== 4'b0010) begin
      errors++; $display("FAIL wd_next: grant=%b, want 0010", grant_out);
    end
`else
    repeat (20) tick();
    checks++;
    if (grant_out !== 4'b0001 || valid_out !== 1'b0 || ready_out !== 4'b0001) begin
      errors++; $display("FAIL lock_hold: grant=%b vld=%b rdy=%b, want 0001/0/0001", grant_out, valid_out, ready_out);
    end
`endif
    valid_in = '0;
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_weight();
    test_last();
    test_backpressure();
    test_watchdog();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
